bdi_comp_sched: RTL

Sequencer and arbiter that shares one BDI compressor/decompressor unit between several requesters, e.g. the cache fill path (compress) and the read/writeback path (decompress). It accepts one request at a time through a valid/ready handshake with round-robin fairness. It issues the request to the shared unit with a one-cycle start pulse, waits for completion under a watchdog, and returns the 256-bit result with its encoding, requester id and tag. It sits between the cache controller and the compressor datapath.

---
 rtl/bdi_pkg.sv | 27 ++
 rtl/bdi_rr_arbiter.sv | 32 +++
 rtl/bdi_comp_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bdi_pkg.sv
// Shared definitions for the BDI compressor sequencer: line width, operation
// codes, encoding codes and the sequencer state type.
package bdi_pkg;

    localparam int LINE_W = 256;

    localparam logic OP_COMP   = 1'b0;
    localparam logic OP_DECOMP = 1'b1;

    localparam logic [3:0] ENC_UNCOMP = 4'd0;
    localparam logic [3:0] ENC_ZERO   = 4'd1;
    localparam logic [3:0] ENC_REP    = 4'd2;
    localparam logic [3:0] ENC_B8D1   = 4'd3;
    localparam logic [3:0] ENC_B8D2   = 4'd4;
    localparam logic [3:0] ENC_B8D4   = 4'd5;
    localparam logic [3:0] ENC_B4D1   = 4'd6;
    localparam logic [3:0] ENC_B4D2   = 4'd7;
    localparam logic [3:0] ENC_B2D1   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/bdi_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index found
// searching upward from ptr, wrapping at NREQ. The pointer lives in the parent.
module bdi_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    enable,
    output logic [NREQ-1:0]         grant
);

    localparam int PTR_W = $clog2(NREQ);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Rotating priority search starting at ptr.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bdi_comp_sched.sv
// Sequencer sharing one BDI compressor/decompressor between NREQ requesters:
// round-robin accept, one-cycle start pulse, watchdog-guarded wait, response.
module bdi_comp_sched
    import bdi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LINE_W  = bdi_pkg::LINE_W,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    input  logic [NREQ*LINE_W-1:0]  req_data,
    output logic                    cu_start,
    output logic                    cu_op,
    output logic [LINE_W-1:0]       cu_din,
    input  logic                    cu_done,
    input  logic [LINE_W-1:0]       cu_dout,
    input  logic [3:0]              cu_enc,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [TAG_W-1:0]        resp_tag,
    output logic [LINE_W-1:0]       resp_data,
    output logic [3:0]              resp_enc,
    output logic                    resp_err
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LINE_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] dout_q, dout_d;
    logic [3:0]        enc_q, enc_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gidx;
    logic              arb_en;

    // Grants only while idle and out of reset, so req_ready is zero during reset.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    bdi_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .enable (arb_en),
        .grant  (grant)
    );

    // One-hot grant to index.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = ID_W'(i);
        end
    end

    // Next-state and capture logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        tag_d    = tag_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        enc_d    = enc_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    id_d     = gidx;
                    op_d     = req_op[gidx];
                    tag_d    = req_tag[gidx*TAG_W +: TAG_W];
                    din_d    = req_data[gidx*LINE_W +: LINE_W];
                    rr_ptr_d = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion in the final watchdog cycle still counts as success.
                if (cu_done) begin
                    dout_d  = cu_dout;
                    enc_d   = cu_enc;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    dout_d  = '0;
                    enc_d   = 4'd0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide line registers are reset too, because their reset value is visible on cu_din/resp_data.
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= 1'b0;
            tag_q    <= '0;
            din_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            enc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            enc_q    <= enc_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = grant;
    assign cu_start   = (state_q == ST_ISSUE);
    assign cu_op      = op_q;
    assign cu_din     = din_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = id_q;
    assign resp_tag   = tag_q;
    assign resp_data  = dout_q;
    assign resp_enc   = enc_q;
    assign resp_err   = err_q;

endmodule
